// File: rtl/xcache_bus_if.sv
// Single-port XCACHE bus between the RISC-V bus arbiter (master) and a memory responder (slave).
interface xcache_bus_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [7:0]            mem_part;
    logic                  mem_re;
    logic [3:0]            mem_we;
    logic [ADDR_WIDTH-1:0] mem_ad;
    logic [DATA_WIDTH-1:0] mem_di;
    logic                  mem_rdy;
    logic [DATA_WIDTH-1:0] mem_do;
    logic                  mem_do_vld;

    modport master (
        output mem_part, mem_re, mem_we, mem_ad, mem_di,
        input  mem_rdy, mem_do, mem_do_vld
    );

    modport slave (
        input  mem_part, mem_re, mem_we, mem_ad, mem_di,
        output mem_rdy, mem_do, mem_do_vld
    );
endinterface

// File: rtl/xcache_bus_responder.sv
// XCACHE bus responder: partitioned byte-writable word storage with fixed-latency,
// in-order read returns and an outstanding-read cap sized for a 4-entry initiator FIFO.
module xcache_bus_responder #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int PART_NUM        = 4,
    parameter int DEPTH_WORDS     = 256,
    parameter int RD_LATENCY      = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             rst,
    xcache_bus_if.slave      bus,
    input  logic             stall,
    output logic [2:0]       outstanding,
    output logic [15:0]      err_cnt
);
    localparam int FLAT_WORDS = PART_NUM * DEPTH_WORDS;
    localparam int FLAT_W     = (FLAT_WORDS > 1) ? $clog2(FLAT_WORDS) : 1;

    logic [DATA_WIDTH-1:0] mem_r [FLAT_WORDS];

    logic [ADDR_WIDTH-3:0] word_idx_s;
    logic [FLAT_W-1:0]     flat_s;
    logic                  in_range_s;
    logic                  req_s;
    logic                  rdy_s;
    logic                  accept_s;
    logic                  rd_accept_s;
    logic                  wr_accept_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic                  unused_addr_lsb_s;

    logic [RD_LATENCY-1:0] pipe_vld_r;
    logic [DATA_WIDTH-1:0] pipe_data_r [RD_LATENCY];
    logic [DATA_WIDTH-1:0] mem_do_r;
    logic                  mem_do_vld_r;
    logic [2:0]            outstanding_r;
    logic [15:0]           err_cnt_r;

    assign word_idx_s        = bus.mem_ad[ADDR_WIDTH-1:2];
    assign unused_addr_lsb_s = ^bus.mem_ad[1:0];
    assign in_range_s        = (bus.mem_part < 8'(PART_NUM)) &&
                               (word_idx_s < (ADDR_WIDTH-2)'(DEPTH_WORDS));
    assign flat_s            = FLAT_W'(bus.mem_part) * FLAT_W'(DEPTH_WORDS) + FLAT_W'(word_idx_s);

    // mem_rdy depends only on registers and stall so no combinational loop forms with the arbiter
    assign req_s       = bus.mem_re | (bus.mem_we != 4'b0000);
    assign rdy_s       = ~rst & ~stall & (outstanding_r < 3'(MAX_OUTSTANDING));
    assign accept_s    = req_s & rdy_s;
    assign rd_accept_s = accept_s & bus.mem_re;
    assign wr_accept_s = accept_s & in_range_s & (bus.mem_we != 4'b0000);

    // Read word sampled before any same-cycle write; out-of-range reads return zero
    always_comb begin
        rd_word_s = '0;
        if (in_range_s) begin
            rd_word_s = mem_r[flat_s];
        end else begin
            rd_word_s = '0;
        end
    end

    // Byte-lane storage update; storage deliberately survives reset
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_we[b]) begin
                    mem_r[flat_s][8*b +: 8] <= bus.mem_di[8*b +: 8];
                end
            end
        end
    end

    // Fixed-latency read return pipeline feeding the registered data outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_r   <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_data_r[i] <= '0;
            end
            mem_do_r     <= '0;
            mem_do_vld_r <= 1'b0;
        end else begin
            pipe_vld_r[0]  <= rd_accept_s;
            pipe_data_r[0] <= rd_word_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
                pipe_data_r[i] <= pipe_data_r[i-1];
            end
            mem_do_vld_r <= pipe_vld_r[RD_LATENCY-1];
            if (pipe_vld_r[RD_LATENCY-1]) begin
                mem_do_r <= pipe_data_r[RD_LATENCY-1];
            end else begin
                mem_do_r <= mem_do_r;
            end
        end
    end

    // In-flight read count drops on the edge that raises mem_do_vld, so mem_rdy reopens in that cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_r <= 3'd0;
        end else begin
            case ({rd_accept_s, pipe_vld_r[RD_LATENCY-1]})
                2'b10:   outstanding_r <= outstanding_r + 3'd1;
                2'b01:   outstanding_r <= outstanding_r - 3'd1;
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Saturating count of accepted out-of-range requests
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 16'd0;
        end else if (accept_s && !in_range_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign bus.mem_rdy    = rdy_s;
    assign bus.mem_do     = mem_do_r;
    assign bus.mem_do_vld = mem_do_vld_r;
    assign outstanding    = outstanding_r;
    assign err_cnt        = err_cnt_r;
endmodule

// File: tb/tb_xcache_bus_responder.sv
// Bench for xcache_bus_responder: directed cap/reset checks on a long-latency instance and
// randomized traffic on a default instance checked against a queue-based reference model.
module tb_xcache_bus_responder;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int PN      = 4;
    localparam int DEPTH   = 256;
    localparam int LAT     = 2;
    localparam int MAXO    = 4;
    localparam int CAP_LAT = 6;

    logic        clk = 1'b0;
    logic        rst, stall, rst_c, stall_c;
    logic [2:0]  outstanding, outstanding_c;
    logic [15:0] err_cnt, err_cnt_c;

    always #5 clk = ~clk;

    xcache_bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    xcache_bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_c ();

    xcache_bus_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PART_NUM(PN), .DEPTH_WORDS(DEPTH),
                           .RD_LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst), .bus(bus), .stall(stall),
        .outstanding(outstanding), .err_cnt(err_cnt));

    xcache_bus_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PART_NUM(PN), .DEPTH_WORDS(DEPTH),
                           .RD_LATENCY(CAP_LAT), .MAX_OUTSTANDING(MAXO)) dut_cap (
        .clk(clk), .rst(rst_c), .bus(bus_c), .stall(stall_c),
        .outstanding(outstanding_c), .err_cnt(err_cnt_c));

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: storage keyed by part*DEPTH+index, pending returns with their due edge
    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_t;

    logic [31:0] ref_mem [int];
    ret_t        ret_q [$];
    int          edge_n  = 0;
    logic [31:0] ref_do  = 32'd0;
    int          ref_err = 0;

    // One bus cycle on the default instance; called at a falling edge, returns at the next one
    task automatic step(input logic r, input logic s, input logic [7:0] part, input logic re,
                        input logic [3:0] we, input logic [31:0] ad, input logic [31:0] di);
        logic        exp_rdy, in_rng, exp_vld;
        int          key;
        logic [31:0] old;
        ret_t        ent;
        rst = r; stall = s;
        bus.mem_part = part; bus.mem_re = re; bus.mem_we = we; bus.mem_ad = ad; bus.mem_di = di;
        #1;
        exp_rdy = !r && !s && (ret_q.size() < MAXO);
        check_val("rdy", bus.mem_rdy, exp_rdy);
        if (r) begin
            ret_q.delete();
            ref_do  = 32'd0;
            ref_err = 0;
        end else if ((re || we != 4'd0) && exp_rdy) begin
            in_rng = (part < PN) && (ad[31:2] < DEPTH);
            key    = int'(part) * DEPTH + int'(ad[31:2] % DEPTH);
            if (re) begin
                ent.due  = edge_n + 1 + LAT;
                ent.data = in_rng ? ref_mem[key] : 32'd0;
                ret_q.push_back(ent);
            end
            if (in_rng && we != 4'd0) begin
                old = ref_mem.exists(key) ? ref_mem[key] : 32'd0;
                for (int b = 0; b < 4; b++)
                    if (we[b]) old[8*b +: 8] = di[8*b +: 8];
                ref_mem[key] = old;
            end
            if (!in_rng && ref_err < 65535) ref_err++;
        end
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        exp_vld = (ret_q.size() > 0) && (ret_q[0].due == edge_n);
        if (exp_vld) begin
            ref_do = ret_q[0].data;
            void'(ret_q.pop_front());
        end
        check_val("vld", bus.mem_do_vld, exp_vld);
        check_val("do", bus.mem_do, ref_do);
        check_val("outstanding", outstanding, ret_q.size());
        check_val("err_cnt", err_cnt, ref_err);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic cap_drive(input logic re, input logic [3:0] we, input logic [31:0] ad, input logic [31:0] di);
        bus_c.mem_part = 8'd2; bus_c.mem_re = re; bus_c.mem_we = we; bus_c.mem_ad = ad; bus_c.mem_di = di;
    endtask

    initial begin
        int          issued, first_acc, nvld, seen;
        logic        acc;
        logic [7:0]  part;
        logic [31:0] ad;
        logic [3:0]  we;
        int          kind;

        rst = 1'b1; stall = 1'b0; rst_c = 1'b1; stall_c = 1'b0;
        bus.mem_part = 8'd0; bus.mem_re = 1'b0; bus.mem_we = 4'd0; bus.mem_ad = 32'd0; bus.mem_di = 32'd0;
        cap_drive(1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_c = 1'b0;

        // Long-latency instance: fill six words, then six back-to-back reads against the cap
        for (int i = 0; i < 6; i++) begin
            cap_drive(1'b0, 4'hF, 32'(i * 4), 32'hC0DE_0000 + 32'(i));
            #1 check_val("cap_wr_rdy", bus_c.mem_rdy, 1'b1);
            @(negedge clk);
        end
        issued = 0; first_acc = -1; nvld = 0;
        for (int n = 0; n < 30; n++) begin
            if (bus_c.mem_do_vld) begin
                check_val("cap_data", bus_c.mem_do, 32'hC0DE_0000 + 32'(nvld));
                if (nvld == 0) begin
                    check_val("cap_latency", n - first_acc, CAP_LAT);
                    check_val("cap_accepts_before_ret", issued, MAXO);
                    check_val("cap_rdy_at_first_vld", bus_c.mem_rdy, 1'b1);
                end
                nvld++;
            end
            cap_drive(issued < 6, 4'd0, 32'(issued * 4), 32'd0);
            #1;
            if (issued == MAXO && nvld == 0) check_val("cap_rdy_low", bus_c.mem_rdy, 1'b0);
            acc = bus_c.mem_re && bus_c.mem_rdy;
            @(negedge clk);
            if (acc) begin
                if (issued == 0) first_acc = n + 1;
                issued++;
            end
        end
        check_val("cap_issued", issued, 6);
        check_val("cap_returns", nvld, 6);
        check_val("cap_outstanding_idle", outstanding_c, 3'd0);

        // Reset with three reads in flight: nothing returns, storage survives
        for (int i = 0; i < 3; i++) begin
            cap_drive(1'b1, 4'd0, 32'(i * 4), 32'd0);
            #1 check_val("rst_rd_rdy", bus_c.mem_rdy, 1'b1);
            @(negedge clk);
        end
        cap_drive(1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst_c = 1'b1;
        #1 check_val("rdy_in_rst", bus_c.mem_rdy, 1'b0);
        @(negedge clk);
        rst_c = 1'b0;
        #1;
        check_val("rst_rdy_after", bus_c.mem_rdy, 1'b1);
        check_val("rst_outstanding", outstanding_c, 3'd0);
        check_val("rst_do", bus_c.mem_do, 32'd0);
        check_val("rst_err", err_cnt_c, 16'd0);
        seen = 0;
        for (int n = 0; n < CAP_LAT + 4; n++) begin
            @(negedge clk);
            if (bus_c.mem_do_vld) seen++;
        end
        check_val("rst_no_vld", seen, 0);
        cap_drive(1'b1, 4'd0, 32'd12, 32'd0);
        @(negedge clk);
        cap_drive(1'b0, 4'd0, 32'd0, 32'd0);
        seen = 0;
        for (int n = 0; n < CAP_LAT + 3 && seen == 0; n++) begin
            @(negedge clk);
            if (bus_c.mem_do_vld) seen = 1;
        end
        check_val("rst_readback_seen", seen, 1);
        check_val("rst_readback_data", bus_c.mem_do, 32'hC0DE_0003);

        // Default instance: reset, then initialise the words the random phase touches
        step(1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        for (int p = 0; p < PN; p++)
            for (int i = 0; i < 8; i++)
                step(1'b0, 1'b0, 8'(p), 1'b0, 4'hF, 32'(i * 4), $urandom);

        step(1'b0, 1'b0, 8'd1, 1'b0, 4'hF, 32'h10, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 8'd1, 1'b1, 4'd0, 32'h10, 32'd0);
        idle();
        idle();
        check_val("wr_then_rd", bus.mem_do, 32'hDEAD_BEEF);

        step(1'b0, 1'b0, 8'd0, 1'b0, 4'hF, 32'h0, 32'h1122_3344);
        step(1'b0, 1'b0, 8'd0, 1'b0, 4'h5, 32'h0, 32'hAABB_CCDD);
        step(1'b0, 1'b0, 8'd0, 1'b1, 4'd0, 32'h0, 32'd0);
        idle();
        idle();
        check_val("byte_enables", bus.mem_do, 32'h11BB_33DD);

        step(1'b0, 1'b0, 8'd2, 1'b0, 4'hF, 32'h8, 32'h0000_0001);
        step(1'b0, 1'b0, 8'd2, 1'b1, 4'hF, 32'h8, 32'h0000_0002);
        step(1'b0, 1'b0, 8'd2, 1'b1, 4'd0, 32'h8, 32'd0);
        idle();
        check_val("rw_same_cycle_old", bus.mem_do, 32'h0000_0001);
        idle();
        check_val("rw_same_cycle_new", bus.mem_do, 32'h0000_0002);

        step(1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 8'd7, 1'b1, 4'd0, 32'h0, 32'd0);
        step(1'b0, 1'b0, 8'd0, 1'b0, 4'hF, 32'(DEPTH * 4), 32'h5555_AAAA);
        idle();
        check_val("oor_read_zero", bus.mem_do, 32'd0);
        check_val("oor_err_cnt", err_cnt, 16'd2);

        // Randomized traffic with stalls, occasional resets and out-of-range requests
        for (int n = 0; n < 2000; n++) begin
            part = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, PN - 1));
            ad   = ($urandom_range(0, 9) == 0) ? {30'(DEPTH + $urandom_range(0, 999)), 2'($urandom)}
                                               : {30'($urandom_range(0, 7)), 2'($urandom)};
            kind = $urandom_range(0, 3);
            we   = (kind >= 2) ? 4'($urandom_range(1, 15)) : 4'd0;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0, part,
                 kind == 1 || kind == 3, we, ad, $urandom);
        end

        step(1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        for (int n = 0; n < 70000; n++)
            step(1'b0, 1'b0, 8'd9, 1'b0, 4'hF, 32'd0, 32'd0);
        check_val("err_saturated", err_cnt, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/xcache_bus_responder.md
Name: xcache_bus_responder

Overview:
- XCACHE-side responder for the single-port bus driven by the RISC-V bus arbiter (mem_part/mem_re/mem_we/mem_ad/mem_di/mem_rdy/mem_do/mem_do_vld).
- Accepts requests under the mem_rdy handshake and services them from partitioned word storage with byte-enable writes.
- Returns read data strictly in order after a fixed latency.
- Caps outstanding reads so the initiator's 4-entry return-index FIFO can never overflow.
- Used as the memory model in subsystem benches and as a scratchpad endpoint in small configurations.

Parameters:
- ADDR_WIDTH, 32, width of mem_ad (byte address).
- DATA_WIDTH, 32, data width. Fixed at 32 because mem_we is 4 byte lanes.
- PART_NUM, 4, number of partitions selectable by mem_part.
- DEPTH_WORDS, 256, words per partition (power of 2).
- RD_LATENCY, 2, cycles from read acceptance to mem_do_vld (>=1).
- MAX_OUTSTANDING, 4, maximum reads accepted but not yet returned (<=4).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_part  in  8  partition select
- mem_re  in  1  read request
- mem_we  in  4  byte write enables
- mem_ad  in  ADDR_WIDTH  byte address; word index = mem_ad[ADDR_WIDTH-1:2]
- mem_di  in  DATA_WIDTH  write data
- mem_rdy  out  1  request accepted this cycle if a request is present
- mem_do  out  DATA_WIDTH  read data
- mem_do_vld  out  1  read data valid, one-cycle pulse per read
- stall  in  1  forces mem_rdy low (contention emulation)
- outstanding  out  3  reads in flight
- err_cnt  out  16  saturating count of accepted out-of-range requests

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-high.
- Reset values: mem_do=0, mem_do_vld=0, outstanding=0, err_cnt=0, latency pipeline cleared. Storage is not cleared.
- mem_rdy = ~rst & ~stall & (outstanding < MAX_OUTSTANDING). It is combinational from registers and stall only. It never depends on mem_re, mem_we or mem_ad, so no loop forms with the arbiter.
- Request present: mem_re | (mem_we != 0).
- Accept: request present & mem_rdy, sampled at the rising edge.
- Write on accept:
  - For each lane b with mem_we[b]=1, storage[part][idx] byte b <= mem_di byte b.
  - Lanes with mem_we[b]=0 are unchanged.
- Read on accept:
  - The storage word is sampled at accept, before any same-cycle write is applied.
  - The sampled word enters a RD_LATENCY-deep shift pipeline with a valid bit.
  - Result: mem_do_vld=1 and mem_do=data exactly RD_LATENCY cycles after the accept edge.
  - When mem_do_vld=0, mem_do holds its previous value.
- Read and write together: both are performed. The read returns pre-write data; the counter counts one read.
- Write followed by read: a read accepted the cycle after a write to the same word returns the new data.
- Write after read: a write accepted after a read was accepted does not alter that read's returned data.
- Out of range: a request is out of range when mem_part >= PART_NUM or word index >= DEPTH_WORDS.
  - An out-of-range write is dropped.
  - An out-of-range read still occupies the pipeline and returns 0.
  - err_cnt increments by 1 per accepted out-of-range request and saturates at 0xFFFF.
- outstanding counter:
  - +1 on read accept; -1 when mem_do_vld=1.
  - Both in the same cycle leave it unchanged.
  - It never exceeds MAX_OUTSTANDING and never underflows.
- Ordering: returns are strictly in acceptance order. No reordering, and mem_do_vld cannot be back-pressured.
- Throughput: one request per cycle while mem_rdy=1. With RD_LATENCY >= MAX_OUTSTANDING, back-to-back reads stall after MAX_OUTSTANDING accepts until the first return.
- stall asserted with reads in flight: returns continue on schedule; only new accepts are blocked.
- rst mid-operation: all in-flight reads are discarded and no mem_do_vld occurs after reset. Writes accepted before reset persist in storage.

Test Plan:
- Write then read: write part=1, ad=0x10, we=0xF, di=0xDEADBEEF; next cycle read the same address -> mem_do_vld exactly 2 cycles after the read accept, mem_do=0xDEADBEEF, outstanding 1 then 0.
- Byte enables: word holds 0x11223344; write we=0x5, di=0xAABBCCDD -> read returns 0x11BB33DD.
- Simultaneous read and write: word holds 0x00000001; re=1, we=0xF, di=0x2 in one cycle -> that read returns 0x1, a following read returns 0x2.
- Outstanding cap (RD_LATENCY=6): 6 back-to-back reads -> mem_rdy falls after the 4th accept and rises in the cycle of the first mem_do_vld; all 6 return in order with correct data.
- Out of range: read part=7, then write ad=DEPTH_WORDS*4 -> the read returns 0 with vld, the write is dropped, err_cnt=2. Driving 70000 bad requests leaves err_cnt=0xFFFF.
- Reset mid-flight: accept 3 reads, assert rst for 1 cycle one cycle later -> no mem_do_vld, outstanding=0, mem_rdy=1 the cycle after rst deasserts, earlier writes still readable.
